trit_unpacker: RTL and testbench
================================

TRIT_UNPACKER -- requirements
Module: trit_unpacker

Interface
REQ-001 SHALL have parameter LANES, default 15: number of output trit lanes; must be a multiple of 5.
REQ-002 SHALL derive localparam BYTES = LANES/5: packed bytes per lane group.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1: synchronous drop of the partial group and of any held output.
REQ-006 SHALL have port in_byte, input, 8: packed byte holding 5 base-3 digits.
REQ-007 SHALL have port in_valid, input, 1: in_byte is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_byte this cycle.
REQ-009 SHALL have port out_trits, output, 2*LANES: unpacked trits; lane k occupies bits [2k+1:2k].
REQ-010 SHALL have port out_valid, output, 1: out_trits holds a complete group.
REQ-011 SHALL have port out_ready, input, 1: the downstream vector engine consumes the group.
REQ-012 SHALL have port err_invalid, output, 1: sticky flag for an illegal byte seen.
REQ-013 SHALL have port group_count, output, 16: count of groups delivered; wraps at 65535 to 0.

Function
REQ-014 SHALL accept a byte when in_valid and in_ready are both high at a rising edge.
REQ-015 SHALL decode byte v as v = d0 + 3*d1 + 9*d2 + 27*d3 + 81*d4, with each di in {0,1,2}.
REQ-016 SHALL encode each digit as: 0 -> 2'b00 (zero), 1 -> 2'b01 (+1), 2 -> 2'b11 (-1); 2'b10 is never emitted.
REQ-017 SHALL map digit di of the j-th accepted byte (j = 0..BYTES-1) of a group to lane 5j+i.
REQ-018 SHALL treat v > 242 as illegal: its 5 lanes output 2'b00, and err_invalid is set the following cycle.
REQ-019 SHALL keep err_invalid set until reset; clear does not clear it.
REQ-020 SHALL track the byte position within the group with a counter 0..BYTES-1 that wraps to 0 after the last byte.
REQ-021 SHALL hold the group under construction in an assembly register and the delivered group in an output register.
REQ-022 SHALL load the completed group directly into the output register on the edge that accepts its last byte, if the output register is empty or drained that same edge.
REQ-023 SHALL otherwise leave the completed group in the assembly register, marked full.
REQ-024 SHALL hold in_ready low while the assembly register is full.
REQ-025 SHALL move the full assembly register into the output register on the edge where out_valid and out_ready are both high, and raise in_ready on the next cycle.
REQ-026 SHALL have a latency of one cycle: out_valid rises the cycle after the last byte is accepted, when the output register is free.
REQ-027 SHALL sustain one byte per cycle when out_ready is held high.
REQ-028 SHALL keep out_trits and out_valid stable while out_valid is high and out_ready is low.
REQ-029 SHALL clear out_valid on a drain edge unless a new group loads on that same edge.
REQ-030 SHALL increment group_count on each out_valid and out_ready handshake.
REQ-031 SHALL, on clear, zero the byte counter, empty both registers, drive out_valid low and in_ready high, and ignore any byte presented that cycle.
REQ-032 SHALL leave group_count unchanged on clear.
REQ-033 SHALL apply clear in preference to any simultaneous accept or drain.

Reset
REQ-034 SHALL, while reset is high, asynchronously force: out_trits 0, out_valid 0, in_ready 1, err_invalid 0, group_count 0, byte counter 0, assembly register empty.
REQ-035 SHALL discard any partial group when reset is asserted mid-group; after release, the next accepted byte is byte 0.

Verification
REQ-036 SHALL verify decode to all +1: with LANES=15 and out_ready=1, three bytes of 121 -> out_trits = {15{2'b01}} one cycle after the third byte, and group_count = 1.
REQ-037 SHALL verify mixed digits: bytes 5, 0, 242 -> lane0 = 11, lane1 = 01, lanes 2-9 = 00, lanes 10-14 = 11.
REQ-038 SHALL verify backpressure: with out_ready=0, feed 6 bytes -> first group held stable, in_ready low after byte 6; raise out_ready -> second group appears on the next cycle and in_ready returns high.
REQ-039 SHALL verify an illegal byte: byte 243 -> its lanes = 00, err_invalid = 1 persisting through clear, cleared only by reset.
REQ-040 SHALL verify clear mid-group: two bytes, then clear, then three bytes of 121 -> a single group of all +1 is delivered.
REQ-041 SHALL verify counter wrap: 65536 handshakes -> group_count = 0.

Source files
------------

// File: rtl/trit_unpacker.sv
// trit_unpacker: turns a stream of packed base-3 bytes (5 trits per byte) into
// groups of LANES two-bit signed trits. One group is assembled while the
// previous one waits downstream; a full assembly register stalls the input.
module trit_unpacker #(
  parameter int LANES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*LANES-1:0] out_trits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_invalid,
  output logic [15:0]        group_count
);

  localparam int BYTES = LANES / 5;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int GW    = 2 * LANES;

  // Split a byte into its five base-3 digits and encode each as 00/01/11.
  // Bytes above 242 cannot be five trits, so their lanes are forced to zero.
  function automatic logic [9:0] decode_byte(input logic [7:0] v);
    logic [7:0] rem;
    logic [7:0] dig;
    decode_byte = '0;
    rem = v;
    for (int i = 0; i < 5; i++) begin
      dig = rem % 8'd3;
      rem = rem / 8'd3;
      decode_byte[2*i +: 2] = (dig == 8'd0) ? 2'b00 :
                              (dig == 8'd1) ? 2'b01 : 2'b11;
    end
    if (v > 8'd242) decode_byte = '0;
  endfunction

  logic [CW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [GW-1:0] asm_reg, asm_next;
  logic          asm_full_reg, asm_full_next;
  logic [GW-1:0] out_reg, out_next;
  logic          out_valid_reg, out_valid_next;
  logic          err_reg;
  logic [15:0]   count_reg;

  logic [GW-1:0] asm_fill;
  logic [9:0]    dec;
  logic          illegal;
  logic          accept;
  logic          drain;
  logic          out_free;
  logic          last_byte;
  logic          load_direct;
  logic          load_from_asm;

  assign dec       = decode_byte(in_byte);
  assign illegal   = in_byte > 8'd242;
  assign in_ready  = ~asm_full_reg;
  assign accept    = in_valid & ~asm_full_reg;
  assign drain     = out_valid_reg & out_ready;
  assign out_free  = ~out_valid_reg | out_ready;
  assign last_byte = byte_cnt_reg == CW'(BYTES - 1);

  // A completed group bypasses the assembly register whenever the output
  // slot is empty or being drained on the same edge.
  assign load_direct   = accept & last_byte & out_free;
  assign load_from_asm = asm_full_reg & drain;

  // Assembly image with the current byte dropped into its 10-bit slot.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_fill
      assign asm_fill[10*gi +: 10] = (byte_cnt_reg == CW'(gi)) ? dec
                                                               : asm_reg[10*gi +: 10];
    end
  endgenerate

  // Next-state selection for the byte counter and both group registers.
  always_comb begin
    byte_cnt_next  = byte_cnt_reg;
    asm_next       = asm_reg;
    asm_full_next  = asm_full_reg;
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    if (accept) begin
      byte_cnt_next = last_byte ? '0 : byte_cnt_reg + CW'(1);
      asm_next      = asm_fill;
      if (last_byte && !out_free) asm_full_next = 1'b1;
    end
    if (load_direct) begin
      out_next       = asm_fill;
      out_valid_next = 1'b1;
    end else if (load_from_asm) begin
      out_next       = asm_reg;
      out_valid_next = 1'b1;
      asm_full_next  = 1'b0;
    end else if (drain) begin
      out_valid_next = 1'b0;
    end
  end

  // Group datapath registers; clear empties everything and wins over traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt_reg  <= '0;
      asm_reg       <= '0;
      asm_full_reg  <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else if (clear) begin
      byte_cnt_reg  <= '0;
      asm_reg       <= '0;
      asm_full_reg  <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      byte_cnt_reg  <= byte_cnt_next;
      asm_reg       <= asm_next;
      asm_full_reg  <= asm_full_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Sticky illegal-byte flag; only reset lowers it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           err_reg <= 1'b0;
    else if (accept && illegal && !clear) err_reg <= 1'b1;
  end

  // Delivered-group counter, free-running 16-bit wrap; clear suppresses a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               count_reg <= '0;
    else if (!clear && drain) count_reg <= count_reg + 16'd1;
  end

  assign out_trits   = out_reg;
  assign out_valid   = out_valid_reg;
  assign err_invalid = err_reg;
  assign group_count = count_reg;

endmodule

// File: tb/tb_trit_unpacker.sv
// Directed bench for trit_unpacker: table of three-byte groups with
// hand-computed trit images, then hand sequences for throughput,
// backpressure, illegal bytes, clear, reset and counter wrap.
module tb_trit_unpacker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, in_valid, in_ready, out_valid, out_ready, err_invalid;
  logic [7:0]  in_byte;
  logic [29:0] out_trits;
  logic [15:0] group_count;

  logic        clear2, in_valid2, in_ready2, out_valid2, out_ready2, err_invalid2;
  logic [7:0]  in_byte2;
  logic [9:0]  out_trits2;
  logic [15:0] group_count2;

  trit_unpacker #(.LANES(15)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .out_trits(out_trits),
    .out_valid(out_valid), .out_ready(out_ready), .err_invalid(err_invalid),
    .group_count(group_count)
  );

  trit_unpacker #(.LANES(5)) dut2 (
    .clk(clk), .reset(reset), .clear(clear2), .in_byte(in_byte2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_trits(out_trits2),
    .out_valid(out_valid2), .out_ready(out_ready2), .err_invalid(err_invalid2),
    .group_count(group_count2)
  );

  typedef struct {
    logic [2:0][7:0] b;
    logic [29:0]     exp;
  } vec_t;

  vec_t vec [5];
  int   total = 0;
  int   bad   = 0;
  int   gc_exp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    in_byte  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vec[0].b = {8'd121, 8'd121, 8'd121}; vec[0].exp = {10'h155, 10'h155, 10'h155};
    vec[1].b = {8'd242, 8'd0,   8'd5};   vec[1].exp = {10'h3FF, 10'h000, 10'h007};
    vec[2].b = {8'd3,   8'd2,   8'd1};   vec[2].exp = {10'h004, 10'h003, 10'h001};
    vec[3].b = {8'd81,  8'd162, 8'd80};  vec[3].exp = {10'h100, 10'h300, 10'h0FF};
    vec[4].b = {8'd0,   8'd0,   8'd200}; vec[4].exp = {10'h000, 10'h000, 10'h353};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_byte = '0; out_ready = 1'b1;
    clear2 = 1'b0; in_valid2 = 1'b0; in_byte2 = '0; out_ready2 = 1'b1;
    #12;
    chk("rst_trits", out_trits, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_err", err_invalid, 0);
    chk("rst_count", group_count, 0);
    @(negedge clk) reset = 1'b0;

    // Table: three bytes back-to-back, group appears after the third, drains next edge.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk("tbl_in_ready", in_ready, 1);
        send_byte(vec[i].b[j]);
        if (j < 2) chk("tbl_early_valid", out_valid, 0);
      end
      chk("tbl_valid", out_valid, 1);
      chk("tbl_trits", out_trits, vec[i].exp);
      $display("vec %0d bytes %0d,%0d,%0d trits=%h", i, vec[i].b[0], vec[i].b[1], vec[i].b[2], out_trits);
      tick();
      gc_exp++;
      chk("tbl_count", group_count, gc_exp);
      chk("tbl_drained", out_valid, 0);
    end

    // Sustained rate: six bytes without a gap, out_ready high.
    send_byte(8'd121); send_byte(8'd121); send_byte(8'd121);
    chk("thr_valid_a", out_valid, 1);
    chk("thr_trits_a", out_trits, {10'h155, 10'h155, 10'h155});
    send_byte(8'd5); gc_exp++;
    chk("thr_ready", in_ready, 1);
    chk("thr_gap", out_valid, 0);
    send_byte(8'd0); send_byte(8'd242);
    chk("thr_trits_b", out_trits, {10'h3FF, 10'h000, 10'h007});
    tick(); gc_exp++;
    chk("thr_count", group_count, gc_exp);
    $display("throughput seq count=%0d", group_count);

    // Backpressure: two groups with out_ready low.
    out_ready = 1'b0;
    send_byte(8'd121); send_byte(8'd121); send_byte(8'd121);
    chk("bp_valid_a", out_valid, 1);
    send_byte(8'd5); send_byte(8'd0);
    chk("bp_hold_a", out_trits, {10'h155, 10'h155, 10'h155});
    chk("bp_ready_mid", in_ready, 1);
    send_byte(8'd242);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_still_a", out_trits, {10'h155, 10'h155, 10'h155});
    chk("bp_still_valid", out_valid, 1);
    chk("bp_count_hold", group_count, gc_exp);
    out_ready = 1'b1;
    tick(); gc_exp++;
    chk("bp_trits_b", out_trits, {10'h3FF, 10'h000, 10'h007});
    chk("bp_valid_b", out_valid, 1);
    chk("bp_ready_back", in_ready, 1);
    chk("bp_count_a", group_count, gc_exp);
    tick(); gc_exp++;
    chk("bp_count_b", group_count, gc_exp);
    chk("bp_drained", out_valid, 0);
    $display("backpressure seq count=%0d", group_count);

    // Illegal byte: lanes zeroed, flag sticky through clear.
    send_byte(8'd243);
    chk("ill_err", err_invalid, 1);
    send_byte(8'd121); send_byte(8'd121);
    chk("ill_trits", out_trits, {10'h155, 10'h155, 10'h000});
    tick(); gc_exp++;
    clear = 1'b1; tick(); clear = 1'b0;
    chk("ill_err_clear", err_invalid, 1);
    chk("ill_count_clear", group_count, gc_exp);
    reset = 1'b1; #2;
    chk("ill_err_reset", err_invalid, 0);
    gc_exp = 0;
    @(negedge clk) reset = 1'b0;
    $display("illegal seq err=%0d", err_invalid);

    // Clear mid-group, with a byte presented during the clear cycle.
    send_byte(8'd121); send_byte(8'd121);
    clear = 1'b1; in_byte = 8'd121; in_valid = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_ready", in_ready, 1);
    send_byte(8'd121);
    chk("clr_v1", out_valid, 0);
    send_byte(8'd121);
    chk("clr_v2", out_valid, 0);
    send_byte(8'd121);
    chk("clr_v3", out_valid, 1);
    chk("clr_trits", out_trits, {10'h155, 10'h155, 10'h155});
    tick(); gc_exp++;
    chk("clr_count", group_count, gc_exp);
    $display("clear seq count=%0d", group_count);

    // Reset mid-group: partial group discarded.
    send_byte(8'd1); send_byte(8'd2);
    reset = 1'b1; #2;
    chk("mrst_trits", out_trits, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_count", group_count, 0);
    gc_exp = 0;
    @(negedge clk) reset = 1'b0;
    send_byte(8'd80); send_byte(8'd162); send_byte(8'd81);
    chk("mrst_valid_new", out_valid, 1);
    chk("mrst_trits_new", out_trits, {10'h100, 10'h300, 10'h0FF});
    tick(); gc_exp++;
    chk("mrst_count_new", group_count, gc_exp);
    $display("reset seq trits ok count=%0d", group_count);

    // Counter wrap on the single-byte-group instance.
    in_byte2 = 8'd121; in_valid2 = 1'b1;
    repeat (65536) tick();
    chk("wrap_pre", group_count2, 16'd65535);
    chk("wrap_valid", out_valid2, 1);
    chk("wrap_trits", out_trits2, 10'h155);
    in_valid2 = 1'b0;
    tick();
    chk("wrap_count", group_count2, 0);
    chk("wrap_drained", out_valid2, 0);
    $display("wrap seq count=%0d", group_count2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
